// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the pipeline hazard/stall controller.
//   state_e        : controller state (RUN, MEM_WAIT)
//   REG_X0         : architectural zero register, never a real dependency
//   DEFAULT_CNT_W  : default width of the performance counters
//   load_use()     : load-use hazard detection between ID and EX
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_X0        = 5'd0;
  localparam int         DEFAULT_CNT_W = 32;

  // A load in EX whose destination is read by the instruction in ID cannot be
  // forwarded in time; x0 never carries a dependency.
  function automatic logic load_use(input logic       ex_mem_read,
                                    input logic [4:0] ex_rd,
                                    input logic [4:0] id_rs1,
                                    input logic [4:0] id_rs2,
                                    input logic       id_use_rs2);
    return ex_mem_read && (ex_rd != REG_X0) &&
           ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));
  endfunction

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear; clear has priority over
// increment and the count sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (count -> 0)
//   inc   : increment request
//   clr   : synchronous clear
//   count : current count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Decides each cycle whether the 5-stage front end advances, stalls (load-use
// bubble), freezes (data-cache busy) or flushes (taken branch in ID). Control
// outputs are Mealy; state, counters and the timeout flag are registered.
//   clk_i, rst_i                      : clock, async active-high reset
//   IF_ID_RS1/RS2/UseRS2              : source operands of instruction in ID
//   ID_EX_MemRead, ID_EX_Rd           : load indication / rd of instruction in EX
//   Branch_Taken_i                    : ID-stage branch resolved taken
//   Mem_Stall_i                       : data cache busy
//   Cnt_Clr_i                         : clear counters and timeout flag
//   PC_Write_o, IF_ID_Write_o         : front-end register enables
//   IF_ID_Flush_o, ID_EX_Bubble_o     : NOP / bubble insertion
//   Pipe_Freeze_o                     : hold EX/MEM and MEM/WB
//   Mem_Timeout_o                     : sticky memory-timeout error
//   LoadUse_Cnt_o, MemWait_Cnt_o, Flush_Cnt_o : saturating perf counters
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_RS1,
  input  logic [4:0]       IF_ID_RS2,
  input  logic             IF_ID_UseRS2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             Branch_Taken_i,
  input  logic             Mem_Stall_i,
  input  logic             Cnt_Clr_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Bubble_o,
  output logic             Pipe_Freeze_o,
  output logic             Mem_Timeout_o,
  output logic [CNT_W-1:0] LoadUse_Cnt_o,
  output logic [CNT_W-1:0] MemWait_Cnt_o,
  output logic [CNT_W-1:0] Flush_Cnt_o
);

  localparam int              TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state, next_state;
  logic             lu;
  logic             lu_inc, mw_inc, fl_inc;
  logic             tmo_inc, tmo_clr;
  logic [TMO_W-1:0] tmo_count;

  assign lu = load_use(ID_EX_MemRead, ID_EX_Rd, IF_ID_RS1, IF_ID_RS2, IF_ID_UseRS2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Once the cache releases, MEM_WAIT resolves exactly like RUN in the same
  // cycle, so the only state-dependent behaviour is timeout accounting.
  always_comb begin
    PC_Write_o     = 1'b1;
    IF_ID_Write_o  = 1'b1;
    IF_ID_Flush_o  = 1'b0;
    ID_EX_Bubble_o = 1'b0;
    Pipe_Freeze_o  = 1'b0;
    next_state     = state;
    lu_inc         = 1'b0;
    mw_inc         = 1'b0;
    fl_inc         = 1'b0;
    tmo_inc        = 1'b0;
    tmo_clr        = 1'b0;
    if (rst_i) begin
      PC_Write_o    = 1'b0;
      IF_ID_Write_o = 1'b0;
      Pipe_Freeze_o = 1'b1;
      next_state    = RUN;
    end else if (Mem_Stall_i) begin
      PC_Write_o    = 1'b0;
      IF_ID_Write_o = 1'b0;
      Pipe_Freeze_o = 1'b1;
      mw_inc        = 1'b1;
      tmo_inc       = (state == MEM_WAIT);
      next_state    = MEM_WAIT;
    end else begin
      next_state = RUN;
      tmo_clr    = 1'b1;
      // A branch is ignored under a load-use stall: its operands are not
      // ready yet, and it is re-evaluated once the bubble has been inserted.
      if (lu) begin
        PC_Write_o     = 1'b0;
        IF_ID_Write_o  = 1'b0;
        ID_EX_Bubble_o = 1'b1;
        lu_inc         = 1'b1;
      end else if (Branch_Taken_i) begin
        IF_ID_Flush_o = 1'b1;
        fl_inc        = 1'b1;
      end
    end
  end

  // The flag is raised on the cycle that brings the consecutive-wait count to
  // MEM_TIMEOUT, so it becomes visible as soon as that count is reached.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      Mem_Timeout_o <= 1'b0;
    end else if (Cnt_Clr_i) begin
      Mem_Timeout_o <= 1'b0;
    end else if (tmo_inc && (tmo_count >= TMO_LAST)) begin
      Mem_Timeout_o <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk(clk_i), .rst(rst_i), .inc(lu_inc), .clr(Cnt_Clr_i), .count(LoadUse_Cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mw_cnt (
    .clk(clk_i), .rst(rst_i), .inc(mw_inc), .clr(Cnt_Clr_i), .count(MemWait_Cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_fl_cnt (
    .clk(clk_i), .rst(rst_i), .inc(fl_inc), .clr(Cnt_Clr_i), .count(Flush_Cnt_o)
  );

  // Counts consecutive MEM_WAIT stall cycles; restarts on every return to RUN.
  sat_counter #(.W(TMO_W)) u_tmo_cnt (
    .clk(clk_i), .rst(rst_i), .inc(tmo_inc), .clr(tmo_clr), .count(tmo_count)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller
// Scoreboard bench: the driver applies one input vector per cycle, computes the
// expected response from a behavioural model and queues it; a monitor pops and
// compares on the falling edge.
module tb_hazard_stall_controller;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 8;
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1, rs2, rd;
  logic             use_rs2, mem_read, br_taken, mem_stall, cnt_clr;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, freeze, timeout;
  logic [CNT_W-1:0] lu_cnt, mw_cnt, fl_cnt;

  typedef struct packed {
    logic             pcw;
    logic             ifw;
    logic             flush;
    logic             bubble;
    logic             freeze;
    logic             tmo;
    logic [CNT_W-1:0] lu;
    logic [CNT_W-1:0] mw;
    logic [CNT_W-1:0] fl;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_waiting;
  int m_lu, m_mw, m_fl, m_wait_run;
  bit m_tmo;

  hazard_stall_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .IF_ID_RS1(rs1), .IF_ID_RS2(rs2), .IF_ID_UseRS2(use_rs2),
    .ID_EX_MemRead(mem_read), .ID_EX_Rd(rd),
    .Branch_Taken_i(br_taken), .Mem_Stall_i(mem_stall), .Cnt_Clr_i(cnt_clr),
    .PC_Write_o(pc_write), .IF_ID_Write_o(ifid_write), .IF_ID_Flush_o(ifid_flush),
    .ID_EX_Bubble_o(idex_bubble), .Pipe_Freeze_o(freeze), .Mem_Timeout_o(timeout),
    .LoadUse_Cnt_o(lu_cnt), .MemWait_Cnt_o(mw_cnt), .Flush_Cnt_o(fl_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic modelReset();
    m_waiting  = 1'b0;
    m_lu       = 0;
    m_mw       = 0;
    m_fl       = 0;
    m_wait_run = 0;
    m_tmo      = 1'b0;
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                               input logic u2, input logic mr, input logic [4:0] d,
                               input logic br, input logic ms, input logic clr);
    exp_t e;
    bit   hazard;
    @(posedge clk);
    #1;
    rst = r; rs1 = s1; rs2 = s2; use_rs2 = u2; mem_read = mr; rd = d;
    br_taken = br; mem_stall = ms; cnt_clr = clr;
    e = '0;
    if (r) begin
      modelReset();
      e.freeze = 1'b1;
    end else begin
      hazard = mr && (d != 5'd0) && ((d == s1) || (u2 && (d == s2)));
      e.tmo = m_tmo;
      e.lu  = CNT_W'(m_lu);
      e.mw  = CNT_W'(m_mw);
      e.fl  = CNT_W'(m_fl);
      if (ms) begin
        e.freeze = 1'b1;
        m_mw = sat_inc(m_mw);
        if (m_waiting) begin
          m_wait_run++;
          if (m_wait_run >= MEM_TIMEOUT) m_tmo = 1'b1;
        end
        m_waiting = 1'b1;
      end else begin
        m_waiting  = 1'b0;
        m_wait_run = 0;
        if (hazard) begin
          e.bubble = 1'b1;
          m_lu = sat_inc(m_lu);
        end else begin
          e.pcw = 1'b1;
          e.ifw = 1'b1;
          if (br) begin
            e.flush = 1'b1;
            m_fl = sat_inc(m_fl);
          end
        end
      end
      if (clr) begin
        m_lu  = 0;
        m_mw  = 0;
        m_fl  = 0;
        m_tmo = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: every cycle the DUT presents a control vector; compare it with
  // the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("PC_Write",    {31'd0, pc_write},    {31'd0, e.pcw});
        checkOutput("IF_ID_Write", {31'd0, ifid_write},  {31'd0, e.ifw});
        checkOutput("IF_ID_Flush", {31'd0, ifid_flush},  {31'd0, e.flush});
        checkOutput("ID_EX_Bubble",{31'd0, idex_bubble}, {31'd0, e.bubble});
        checkOutput("Pipe_Freeze", {31'd0, freeze},      {31'd0, e.freeze});
        checkOutput("Mem_Timeout", {31'd0, timeout},     {31'd0, e.tmo});
        checkOutput("LoadUse_Cnt", 32'(lu_cnt), 32'(e.lu));
        checkOutput("MemWait_Cnt", 32'(mw_cnt), 32'(e.mw));
        checkOutput("Flush_Cnt",   32'(fl_cnt), 32'(e.fl));
      end
    end
  end

  initial begin
    int burst;
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; use_rs2 = 0; mem_read = 0;
    br_taken = 0; mem_stall = 0; cnt_clr = 0;
    modelReset();

    $display("[TB] directed sequence");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use on rs1, then rd = x0
    applyStimulus(0, 5, 0, 0, 1, 5, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // rs2 match only counts when rs2 is used
    applyStimulus(0, 3, 5, 0, 1, 5, 0, 0, 0);
    applyStimulus(0, 3, 5, 1, 1, 5, 0, 0, 0);
    idle(1);
    // freeze with a pending branch, then flush on release
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    // long stall reaching the timeout, then clear
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // load-use beats branch; branch taken the cycle after
    applyStimulus(0, 5, 0, 0, 1, 5, 1, 0, 0);
    applyStimulus(0, 5, 0, 0, 0, 5, 1, 0, 0);
    idle(1);
    // counter saturation
    for (int i = 0; i < CMAX + 4; i++) applyStimulus(0, 7, 0, 0, 1, 7, 0, 0, 0);
    idle(1);
    // increment coinciding with clear
    applyStimulus(0, 7, 0, 0, 1, 7, 0, 0, 1);
    idle(1);
    // reset in the middle of a stall after the timeout fired
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    $display("[TB] random sequence");
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      logic ms;
      if (burst == 0 && $urandom_range(0, 49) == 0) burst = $urandom_range(8, 14);
      if (burst > 0) begin
        ms = 1'b1;
        burst--;
      end else begin
        ms = ($urandom_range(0, 9) < 2);
      end
      applyStimulus($urandom_range(0, 199) == 0,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                    ms, ($urandom_range(0, 59) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
